// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product master and its sequencer:
// widths, state encodings, response codes and the latched config payload.
package dot_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned LEN_W          = 32;
  localparam int unsigned ACC_W          = 64;
  localparam int unsigned DOT_WORD_BYTES = 4;
  localparam int unsigned ST_W           = 4;

  localparam logic [ST_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [ST_W-1:0] ST_RD_A    = 4'd1;
  localparam logic [ST_W-1:0] ST_RD_B    = 4'd2;
  localparam logic [ST_W-1:0] ST_MAC     = 4'd3;
  localparam logic [ST_W-1:0] ST_CDONE   = 4'd4;
  localparam logic [ST_W-1:0] ST_WR      = 4'd5;
  localparam logic [ST_W-1:0] ST_WR_RESP = 4'd6;
  localparam logic [ST_W-1:0] ST_WDONE   = 4'd7;
  localparam logic [ST_W-1:0] ST_RB_ADDR = 4'd8;
  localparam logic [ST_W-1:0] ST_RB_DATA = 4'd9;
  localparam logic [ST_W-1:0] ST_RDONE   = 4'd10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] waddr_a;
    logic [ADDR_W-1:0] waddr_b;
    logic [ADDR_W-1:0] waddr_out;
    logic [LEN_W-1:0]  len;
  } cfg_t;

  // Byte address of element idx in a vector starting at base.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx,
                                                  input int unsigned       stride);
    return base + ADDR_W'(idx * stride);
  endfunction

endpackage

// File: rtl/dot_product_master_if.sv
// Memory read/write channel bundle between the dot-product master and memory.
interface dot_product_master_if;
  import dot_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid;
  logic              rready;
  logic [1:0]        rresp;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    input  arready, m_rdata, m_rvalid, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    output arready, m_rdata, m_rvalid, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/dot_mac.sv
// 64-bit unsigned multiply-accumulate with synchronous clear and enable.
module dot_mac
  import dot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_prod;

  assign w_prod = ACC_W'(i_a) * ACC_W'(i_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc + w_prod;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dot_product_master.sv
// Fetches two vectors element by element, accumulates their dot product,
// writes the low word to memory and reads it back for the sequencer.
module dot_product_master
  import dot_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DOT_WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start_fetch,
  input  logic              i_start_compute,
  input  logic              i_start_write,
  input  logic              i_start_read,
  input  logic [ADDR_W-1:0] i_waddr_a,
  input  logic [ADDR_W-1:0] i_waddr_b,
  input  logic [ADDR_W-1:0] i_waddr_output,
  input  logic [LEN_W-1:0]  i_vector_len,
  output logic              o_processing_done,
  output logic              o_store_done,
  output logic              o_read_done,
  output logic              o_status,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_rvalid,
  dot_product_master_if.master mem
);

  logic [ST_W-1:0]   r_state,     w_state_nxt;
  cfg_t              r_cfg,       w_cfg_nxt;
  logic [LEN_W-1:0]  r_idx,       w_idx_nxt,  w_idx_inc;
  logic [DATA_W-1:0] r_a,         w_a_nxt;
  logic [DATA_W-1:0] r_b,         w_b_nxt;
  logic [ADDR_W-1:0] r_araddr,    w_araddr_nxt;
  logic              r_arvalid,   w_arvalid_nxt;
  logic              r_rready,    w_rready_nxt;
  logic [ADDR_W-1:0] r_awaddr,    w_awaddr_nxt;
  logic              r_awvalid,   w_awvalid_nxt;
  logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;
  logic              r_wvalid,    w_wvalid_nxt;
  logic              r_bready,    w_bready_nxt;
  logic              r_status,    w_status_nxt;
  logic [DATA_W-1:0] r_read_data, w_read_data_nxt;
  logic              r_rvalid,    w_rvalid_nxt;
  logic              r_proc_done, r_store_done, r_read_done;
  logic              w_mac_clr,   w_mac_en;
  logic [ACC_W-1:0]  w_acc;

  assign w_idx_inc = r_idx + LEN_W'(1);

  dot_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_acc (w_acc)
  );

  // Next state and next value of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_cfg_nxt       = r_cfg;
    w_idx_nxt       = r_idx;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_araddr_nxt    = r_araddr;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_awaddr_nxt    = r_awaddr;
    w_awvalid_nxt   = r_awvalid;
    w_wdata_nxt     = r_wdata;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_status_nxt    = r_status;
    w_read_data_nxt = r_read_data;
    w_rvalid_nxt    = 1'b0;
    w_mac_clr       = 1'b0;
    w_mac_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start_fetch) begin
          w_cfg_nxt.waddr_a   = i_waddr_a;
          w_cfg_nxt.waddr_b   = i_waddr_b;
          w_cfg_nxt.waddr_out = i_waddr_output;
          w_cfg_nxt.len       = i_vector_len;
          w_idx_nxt           = '0;
          w_status_nxt        = 1'b0;
          w_mac_clr           = 1'b1;
        end else if (i_start_compute) begin
          if (r_cfg.len != '0) begin
            w_state_nxt   = ST_RD_A;
            w_araddr_nxt  = elem_addr(r_cfg.waddr_a, r_idx, WORD_BYTES);
            w_arvalid_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_CDONE;
            w_mac_clr   = 1'b1;
          end
        end
      end
      ST_RD_A, ST_RD_B: begin
        if (r_arvalid && mem.arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
        // rready only rises after the address is accepted, so data is taken once
        if (r_rready && mem.m_rvalid) begin
          w_rready_nxt = 1'b0;
          w_status_nxt = r_status | (mem.rresp != RESP_OKAY);
          if (r_state == ST_RD_A) begin
            w_a_nxt       = mem.m_rdata;
            w_state_nxt   = ST_RD_B;
            w_araddr_nxt  = elem_addr(r_cfg.waddr_b, r_idx, WORD_BYTES);
            w_arvalid_nxt = 1'b1;
          end else begin
            w_b_nxt     = mem.m_rdata;
            w_state_nxt = ST_MAC;
          end
        end
      end
      ST_MAC: begin
        w_mac_en  = 1'b1;
        w_idx_nxt = w_idx_inc;
        if (w_idx_inc < r_cfg.len) begin
          w_state_nxt   = ST_RD_A;
          w_araddr_nxt  = elem_addr(r_cfg.waddr_a, w_idx_inc, WORD_BYTES);
          w_arvalid_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_CDONE;
        end
      end
      ST_CDONE: begin
        w_status_nxt = r_status | (|w_acc[ACC_W-1:DATA_W]);
        if (i_start_write) begin
          w_state_nxt   = ST_WR;
          w_awaddr_nxt  = r_cfg.waddr_out;
          w_awvalid_nxt = 1'b1;
          w_wdata_nxt   = w_acc[DATA_W-1:0];
          w_wvalid_nxt  = 1'b1;
        end
      end
      ST_WR: begin
        if (r_awvalid && mem.awready) w_awvalid_nxt = 1'b0;
        if (r_wvalid && mem.wready)   w_wvalid_nxt  = 1'b0;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_state_nxt  = ST_WR_RESP;
          w_bready_nxt = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (mem.bvalid) begin
          w_bready_nxt = 1'b0;
          w_status_nxt = r_status | (mem.bresp != RESP_OKAY);
          w_state_nxt  = ST_WDONE;
        end
      end
      ST_WDONE: begin
        if (i_start_read) begin
          w_state_nxt   = ST_RB_ADDR;
          w_araddr_nxt  = r_cfg.waddr_out;
          w_arvalid_nxt = 1'b1;
        end
      end
      ST_RB_ADDR: begin
        if (r_arvalid && mem.arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = ST_RB_DATA;
        end
      end
      ST_RB_DATA: begin
        if (r_rready && mem.m_rvalid) begin
          w_rready_nxt    = 1'b0;
          w_read_data_nxt = mem.m_rdata;
          w_rvalid_nxt    = 1'b1;
          w_status_nxt    = r_status | (mem.rresp != RESP_OKAY);
          w_state_nxt     = ST_RDONE;
        end
      end
      ST_RDONE: begin
        if (!i_start_read) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cfg        <= '0;
      r_idx        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_awvalid    <= 1'b0;
      r_wdata      <= '0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_status     <= 1'b0;
      r_read_data  <= '0;
      r_rvalid     <= 1'b0;
      r_proc_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_read_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cfg        <= w_cfg_nxt;
      r_idx        <= w_idx_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_araddr     <= w_araddr_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_awaddr     <= w_awaddr_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_status     <= w_status_nxt;
      r_read_data  <= w_read_data_nxt;
      r_rvalid     <= w_rvalid_nxt;
      r_proc_done  <= (w_state_nxt == ST_CDONE);
      r_store_done <= (w_state_nxt == ST_WDONE);
      r_read_done  <= (w_state_nxt == ST_RDONE);
    end
  end

  assign mem.araddr        = r_araddr;
  assign mem.arvalid       = r_arvalid;
  assign mem.rready        = r_rready;
  assign mem.awaddr        = r_awaddr;
  assign mem.awvalid       = r_awvalid;
  assign mem.wdata         = r_wdata;
  assign mem.wvalid        = r_wvalid;
  assign mem.bready        = r_bready;
  assign o_processing_done = r_proc_done;
  assign o_store_done      = r_store_done;
  assign o_read_done       = r_read_done;
  assign o_status          = r_status;
  assign o_read_data       = r_read_data;
  assign o_rvalid          = r_rvalid;

endmodule

// File: tb/tb_dot_product_master.sv
// Scoreboard bench: randomized vectors against an arithmetic dot-product
// model, with a memory responder that stalls ready and delays read data.
module tb_dot_product_master;
  import dot_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_start_fetch = 0, i_start_compute = 0, i_start_write = 0, i_start_read = 0;
  logic [31:0] i_waddr_a = 0, i_waddr_b = 0, i_waddr_output = 0, i_vector_len = 0;
  logic        o_processing_done, o_store_done, o_read_done, o_status, o_rvalid;
  logic [31:0] o_read_data;

  dot_product_master_if mem ();

  dot_product_master dut (
    .clk               (clk),
    .rst               (rst),
    .i_start_fetch     (i_start_fetch),
    .i_start_compute   (i_start_compute),
    .i_start_write     (i_start_write),
    .i_start_read      (i_start_read),
    .i_waddr_a         (i_waddr_a),
    .i_waddr_b         (i_waddr_b),
    .i_waddr_output    (i_waddr_output),
    .i_vector_len      (i_vector_len),
    .o_processing_done (o_processing_done),
    .o_store_done      (o_store_done),
    .o_read_done       (o_read_done),
    .o_status          (o_status),
    .o_read_data       (o_read_data),
    .o_rvalid          (o_rvalid),
    .mem               (mem)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        status;
  } exp_t;

  int          checks = 0, failures = 0;
  exp_t        wr_q[$], rd_q[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] va[$], vb[$];
  int          ar_stall = 0, aw_stall = 0, w_stall = 0, rd_min = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  int          ar_count = 0, aw_count = 0, w_count = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Handshakes seen at the rising edge, consumed by the negedge responders.
  logic        s_ar_hs = 0, s_r_hs = 0, s_aw_hs = 0, s_w_hs = 0, s_b_hs = 0;
  logic [31:0] s_araddr = 0, s_awaddr = 0, s_wdata = 0;
  always @(posedge clk) begin
    s_ar_hs  = mem.arvalid && mem.arready;
    s_r_hs   = mem.rready && mem.m_rvalid;
    s_aw_hs  = mem.awvalid && mem.awready;
    s_w_hs   = mem.wvalid && mem.wready;
    s_b_hs   = mem.bvalid && mem.bready;
    s_araddr = mem.araddr;
    s_awaddr = mem.awaddr;
    s_wdata  = mem.wdata;
  end

  // Read responder: stalled arready, delayed data, address-stability monitor.
  int          ar_wait = 0, rd_lat = 0;
  logic        rd_pend = 0, prev_ar_pend = 0;
  logic [31:0] rd_addr = 0, prev_araddr = 0;
  always @(negedge clk) begin
    if (!rst) begin
      mem.arready = 0; mem.m_rvalid = 0; mem.m_rdata = 0; mem.rresp = 2'b00;
      rd_pend = 0; ar_wait = 0; prev_ar_pend = 0;
    end else begin
      if (prev_ar_pend && !s_ar_hs)
        check("araddr_stable", {31'd0, mem.arvalid, mem.araddr}, {31'd0, 1'b1, prev_araddr});
      if (s_r_hs) begin
        mem.m_rvalid = 0;
        rd_pend = 0;
      end
      if (s_ar_hs) begin
        mem.arready = 0;
        rd_addr = s_araddr;
        rd_pend = 1;
        rd_lat = rd_min + int'($urandom_range(0, 2));
        ar_wait = 0;
        ar_count++;
      end else if (mem.arvalid && !mem.arready) begin
        if (ar_wait >= ar_stall) mem.arready = 1;
        else ar_wait++;
      end
      if (rd_pend && !mem.m_rvalid) begin
        if (rd_lat == 0) begin
          mem.m_rvalid = 1;
          mem.m_rdata  = mem_model.exists(rd_addr) ? mem_model[rd_addr] : 32'hDEAD_BEEF;
          mem.rresp    = 2'b00;
        end else rd_lat--;
      end
      prev_ar_pend = mem.arvalid;
      prev_araddr  = mem.araddr;
    end
  end

  // Write responder with independent awready/wready stalls; scoreboard on completion.
  int          aw_wait = 0, w_wait = 0;
  logic        got_aw = 0, got_w = 0;
  logic [31:0] wr_addr = 0, wr_data = 0;
  exp_t        we;
  always @(negedge clk) begin
    if (!rst) begin
      mem.awready = 0; mem.wready = 0; mem.bvalid = 0; mem.bresp = 2'b00;
      got_aw = 0; got_w = 0; aw_wait = 0; w_wait = 0;
    end else begin
      if (s_b_hs) begin
        mem.bvalid = 0;
        got_aw = 0;
        got_w = 0;
      end
      if (s_aw_hs) begin
        mem.awready = 0; got_aw = 1; wr_addr = s_awaddr; aw_count++; aw_wait = 0;
      end else if (mem.awvalid && !mem.awready && !got_aw) begin
        if (aw_wait >= aw_stall) mem.awready = 1;
        else aw_wait++;
      end
      if (s_w_hs) begin
        mem.wready = 0; got_w = 1; wr_data = s_wdata; w_count++; w_wait = 0;
      end else if (mem.wvalid && !mem.wready && !got_w) begin
        if (w_wait >= w_stall) mem.wready = 1;
        else w_wait++;
      end
      if (got_aw && got_w && !mem.bvalid) begin
        mem.bvalid = 1;
        mem.bresp  = cfg_bresp;
        mem_model[wr_addr] = wr_data;
        if (wr_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
        else begin
          we = wr_q.pop_front();
          check("write_addr", 64'(wr_addr), 64'(we.addr));
          check("write_data", 64'(wr_data), 64'(we.data));
        end
      end
    end
  end

  // Readback monitor.
  exp_t re;
  always @(negedge clk) begin
    if (rst && o_rvalid) begin
      if (rd_q.size() == 0) check("unexpected_rvalid", 64'd1, 64'd0);
      else begin
        re = rd_q.pop_front();
        check("read_data", 64'(o_read_data), 64'(re.data));
        check("read_status", 64'(o_status), 64'(re.status));
      end
    end
  end

  function automatic logic done_sig(input int sel);
    case (sel)
      0:       return o_processing_done;
      1:       return o_store_done;
      default: return o_read_done;
    endcase
  endfunction

  task automatic wait_level(input int sel, input logic lvl, input string name, output int cyc);
    cyc = 0;
    while (done_sig(sel) !== lvl && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) check({name, "_timeout"}, 64'(done_sig(sel)), 64'(lvl));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_flags"}, 64'({o_processing_done, o_store_done, o_read_done, o_status, o_rvalid,
                                mem.arvalid, mem.rready, mem.awvalid, mem.wvalid, mem.bready,
                                o_read_data}), 64'd0);
    check({tag, "_addr"}, {mem.araddr, mem.awaddr}, 64'd0);
    check({tag, "_wdata"}, 64'(mem.wdata), 64'd0);
  endtask

  task automatic run_dot(input int len, input logic [31:0] ba, input logic [31:0] bb,
                         input logic [31:0] wo, input logic [1:0] br, input int ars,
                         input int aws, input int ws, input bit abort);
    logic [63:0] acc;
    logic        st;
    exp_t        e;
    int          cyc, ar0, aw0, w0;
    acc = '0;
    for (int i = 0; i < len; i++) begin
      mem_model[ba + 32'(4 * i)] = va[i];
      mem_model[bb + 32'(4 * i)] = vb[i];
      acc = acc + 64'(va[i]) * 64'(vb[i]);
    end
    st = (acc[63:32] != 32'd0) || (br != 2'b00);
    ar_stall = ars; aw_stall = aws; w_stall = ws; cfg_bresp = br;
    rd_min = abort ? 10 : 0;
    i_waddr_a = ba; i_waddr_b = bb; i_waddr_output = wo; i_vector_len = 32'(len);
    i_start_fetch = 1;
    @(negedge clk);
    i_start_fetch = 0;
    i_start_compute = 1;
    ar0 = ar_count;
    if (abort) begin
      cyc = 0;
      while (ar_count < ar0 + 2 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 2000) check("abort_reach_rd_b_timeout", 64'(ar_count - ar0), 64'd2);
      #2 rst = 0;
      #1 check_outputs_zero("midrun_reset");
      i_start_compute = 0;
      repeat (2) @(negedge clk);
      #2 rst = 1;
      @(negedge clk);
      return;
    end
    e.addr = wo; e.data = acc[31:0]; e.status = st;
    wr_q.push_back(e);
    rd_q.push_back(e);
    wait_level(0, 1'b1, "processing_done", cyc);
    if (len == 0) begin
      check("len0_latency_le2", 64'(cyc <= 2), 64'd1);
      check("len0_no_ar", 64'(ar_count - ar0), 64'd0);
    end
    aw0 = aw_count; w0 = w_count;
    i_start_write = 1;
    wait_level(1, 1'b1, "store_done", cyc);
    check("single_write", {32'(aw_count - aw0), 32'(w_count - w0)}, {32'd1, 32'd1});
    check("status_at_store", 64'(o_status), 64'(st));
    i_start_compute = 0;
    i_start_write = 0;
    i_start_read = 1;
    wait_level(2, 1'b1, "read_done", cyc);
    i_start_read = 0;
    wait_level(2, 1'b0, "return_idle", cyc);
    @(negedge clk);
  endtask

  task automatic fill_random(input int len);
    va.delete(); vb.delete();
    for (int i = 0; i < len; i++) begin
      va.push_back($urandom);
      vb.push_back($urandom);
    end
  endtask

  initial begin
    #1 rst = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    #2 rst = 1;
    @(negedge clk);

    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_dot(4, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 2'b00, 0, 0, 0, 1'b0);

    va.delete(); vb.delete();
    run_dot(0, 32'h0000_1100, 32'h0000_2100, 32'h0000_3100, 2'b00, 0, 0, 0, 1'b0);

    va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_dot(2, 32'h0000_1200, 32'h0000_2200, 32'h0000_3200, 2'b00, 0, 0, 0, 1'b0);

    fill_random(3);
    run_dot(3, 32'h0000_1300, 32'h0000_2300, 32'h0000_3300, 2'b00, 5, 0, 3, 1'b0);

    fill_random(8);
    run_dot(8, 32'h0000_1400, 32'h0000_2400, 32'h0000_3400, 2'b00, 0, 0, 0, 1'b1);
    fill_random(8);
    run_dot(8, 32'h0000_1500, 32'h0000_2500, 32'h0000_3500, 2'b00, 1, 2, 0, 1'b0);

    va = '{32'd9, 32'd10};
    vb = '{32'd3, 32'd4};
    run_dot(2, 32'h0000_1600, 32'h0000_2600, 32'h0000_3600, 2'b10, 0, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int len;
      len = int'($urandom_range(1, 6));
      fill_random(len);
      run_dot(len, 32'h0001_0000 + 32'(r * 256), 32'h0002_0000 + 32'(r * 256),
              32'h0003_0000 + 32'(r * 4), 2'b00, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", {32'(wr_q.size()), 32'(rd_q.size())}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
